// File: rtl/clk_gate_ctrl.sv
// Automatic clock-gating controller: per-domain idle gating with a round-robin,
// one-at-a-time wake arbiter so that domain clocks never start together.
module clk_gate_ctrl #(
  parameter int unsigned NumDomains = 4,
  parameter int unsigned IdleCycles = 16,
  parameter int unsigned WakeCycles = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_en_i,
  input  logic [NumDomains-1:0]   busy_i,
  input  logic [NumDomains-1:0]   wake_req_i,
  input  logic [NumDomains-1:0]   force_on_i,
  output logic [NumDomains-1:0]   clk_en_o,
  output logic [NumDomains-1:0]   ready_o,
  output logic [2*NumDomains-1:0] state_o
);

  localparam int unsigned CntMax = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned PtrW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_e;

  state_e                state_q [NumDomains];
  state_e                state_d [NumDomains];
  logic [CntW-1:0]       cnt_q   [NumDomains];
  logic [CntW-1:0]       cnt_d   [NumDomains];
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NumDomains-1:0] clk_en_q, clk_en_d;
  logic [NumDomains-1:0] ready_q, ready_d;

  logic [NumDomains-1:0] act;
  logic [NumDomains-1:0] pending;
  logic                  waking;
  logic                  grant_vld;
  logic [PtrW-1:0]       grant_idx;
  logic [PtrW-1:0]       scan_idx;

  assign act = busy_i | wake_req_i | force_on_i;

  // Wake candidates and the "a domain is still settling" blocker.
  always_comb begin
    pending = '0;
    waking  = 1'b0;
    for (int unsigned d = 0; d < NumDomains; d++) begin
      pending[d] = (state_q[d] == S_OFF) && act[d];
      if (state_q[d] == S_WAKE) waking = 1'b1;
    end
  end

  // Round-robin grant: first pending index at or after the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    ptr_d     = ptr_q;
    if (!waking) begin
      for (int unsigned i = 0; i < NumDomains; i++) begin
        scan_idx = PtrW'((32'(ptr_q) + i) % NumDomains);
        if (!grant_vld && pending[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) begin
      ptr_d = (grant_idx == PtrW'(NumDomains - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  // Per-domain next state; outputs decoded from the next state so they register with it.
  always_comb begin
    clk_en_d = '0;
    ready_d  = '0;
    for (int unsigned d = 0; d < NumDomains; d++) begin
      state_d[d] = state_q[d];
      cnt_d[d]   = cnt_q[d];
      case (state_q[d])
        S_OFF: begin
          if (grant_vld && (grant_idx == PtrW'(d))) begin
            state_d[d] = S_WAKE;
            cnt_d[d]   = CntW'(WakeCycles - 1);
          end
        end
        S_WAKE: begin
          if (cnt_q[d] == '0) state_d[d] = S_ON;
          else                cnt_d[d]   = cnt_q[d] - CntW'(1);
        end
        S_ON: begin
          if (!act[d]) begin
            state_d[d] = S_IDLE;
            cnt_d[d]   = CntW'(IdleCycles - 1);
          end
        end
        S_IDLE: begin
          if (act[d])              state_d[d] = S_ON;
          else if (cnt_q[d] == '0) state_d[d] = S_OFF;
          else                     cnt_d[d]   = cnt_q[d] - CntW'(1);
        end
        default: begin
          state_d[d] = S_OFF;
          cnt_d[d]   = '0;
        end
      endcase
      clk_en_d[d] = (state_d[d] != S_OFF);
      ready_d[d]  = (state_d[d] == S_ON) || (state_d[d] == S_IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned d = 0; d < NumDomains; d++) begin
        state_q[d] <= S_OFF;
        cnt_q[d]   <= '0;
      end
      ptr_q    <= '0;
      clk_en_q <= '0;
      ready_q  <= '0;
    end else begin
      for (int unsigned d = 0; d < NumDomains; d++) begin
        state_q[d] <= state_d[d];
        cnt_q[d]   <= cnt_d[d];
      end
      ptr_q    <= ptr_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_o = '0;
    for (int unsigned d = 0; d < NumDomains; d++) begin
      state_o[2*d +: 2] = state_q[d];
    end
  end

  // Test mode overrides only the gate enables.
  assign clk_en_o = clk_en_q | {NumDomains{test_en_i}};
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vector table, latency sequences, and random
// traffic against a time-stamp based reference model.
module tb_clk_gate_ctrl;

  localparam int N = 4;
  localparam int I = 16;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           test_en;
  logic [N-1:0]   busy, wake, frc;
  logic [N-1:0]   clk_en_o, ready_o;
  logic [2*N-1:0] state_o;

  clk_gate_ctrl #(
    .NumDomains(N),
    .IdleCycles(I),
    .WakeCycles(W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .test_en_i (test_en),
    .busy_i    (busy),
    .wake_req_i(wake),
    .force_on_i(frc),
    .clk_en_o  (clk_en_o),
    .ready_o   (ready_o),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a domain is running since grant edge m_g; it is settled W edges
  // later, and it gates after I+1 consecutive inactive edges while settled.
  bit             m_run   [N];
  int             m_g     [N];
  int             m_quiet [N];
  int             m_ptr;
  int             m_edge;
  logic [N-1:0]   m_en, m_rdy;
  logic [2*N-1:0] m_st;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  task automatic model_outputs();
    m_en = '0; m_rdy = '0; m_st = '0;
    for (int d = 0; d < N; d++) begin
      if (m_run[d]) begin
        m_en[d]  = 1'b1;
        m_rdy[d] = (m_edge >= m_g[d] + W);
        if (m_edge < m_g[d] + W) m_st[2*d +: 2] = 2'd1;
        else if (m_quiet[d] == 0) m_st[2*d +: 2] = 2'd2;
        else m_st[2*d +: 2] = 2'd3;
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_run[d] = 1'b0; m_g[d] = 0; m_quiet[d] = 0;
    end
    m_ptr = 0; m_edge = 0;
    model_outputs();
  endtask

  task automatic model_step();
    logic [N-1:0] act;
    bit           settling;
    bit           was_off [N];
    bit           found;
    int           e, d;
    act = busy | wake | frc;
    m_edge++;
    e = m_edge;
    settling = 1'b0;
    for (int k = 0; k < N; k++) begin
      was_off[k] = !m_run[k];
      if (m_run[k] && (e - 1 < m_g[k] + W)) settling = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (m_run[k] && (e - 1 >= m_g[k] + W)) begin
        if (act[k]) m_quiet[k] = 0;
        else m_quiet[k]++;
        if (m_quiet[k] == I + 1) begin
          m_run[k] = 1'b0; m_quiet[k] = 0;
        end
      end
    end
    found = 1'b0;
    if (!settling) begin
      for (int k = 0; k < N; k++) begin
        d = (m_ptr + k) % N;
        if (!found && was_off[d] && act[d]) begin
          found = 1'b1;
          m_run[d] = 1'b1; m_g[d] = e; m_quiet[d] = 0;
          m_ptr = (d + 1) % N;
        end
      end
    end
    model_outputs();
  endtask

  task automatic tick(input bit cmp);
    @(posedge clk);
    model_step();
    #1;
    if (cmp) begin
      check("clk_en_o", 32'(clk_en_o), 32'(m_en | {N{test_en}}));
      check("ready_o",  32'(ready_o),  32'(m_rdy));
      check("state_o",  32'(state_o),  32'(m_st));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic           test_en;
    logic [N-1:0]   wake;
    logic [N-1:0]   exp_en;
    logic [N-1:0]   exp_rdy;
    logic [2*N-1:0] exp_st;
  } vec_t;

  vec_t tbl [8];
  int   rise [N];
  int   drop, viol;

  initial begin
    tbl[0] = '{1'b0, 4'b0000, 4'h0, 4'h0, 8'h00};
    tbl[1] = '{1'b1, 4'b0000, 4'hF, 4'h0, 8'h00};
    tbl[2] = '{1'b0, 4'b0010, 4'h2, 4'h0, 8'h04};
    tbl[3] = '{1'b0, 4'b0010, 4'h2, 4'h0, 8'h04};
    tbl[4] = '{1'b0, 4'b0010, 4'h2, 4'h0, 8'h04};
    tbl[5] = '{1'b0, 4'b0010, 4'h2, 4'h0, 8'h04};
    tbl[6] = '{1'b0, 4'b0010, 4'h2, 4'h2, 8'h08};
    tbl[7] = '{1'b0, 4'b0000, 4'h2, 4'h2, 8'h0C};

    test_en = 1'b0; busy = '0; wake = '0; frc = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_clk_en", 32'(clk_en_o), 32'h0);
    check("rst_ready",  32'(ready_o),  32'h0);
    check("rst_state",  32'(state_o),  32'h0);
    test_en = 1'b1;
    #1;
    check("rst_test_en", 32'(clk_en_o), 32'hF);
    check("rst_test_rdy", 32'(ready_o), 32'h0);
    test_en = 1'b0;
    do_reset();

    // Directed vectors: test mode, then a single wake of domain 1 and its first idle cycle.
    for (int r = 0; r < 8; r++) begin
      test_en = tbl[r].test_en;
      wake    = tbl[r].wake;
      tick(1'b0);
      check($sformatf("vec%0d_en", r),  32'(clk_en_o), 32'(tbl[r].exp_en));
      check($sformatf("vec%0d_rdy", r), 32'(ready_o),  32'(tbl[r].exp_rdy));
      check($sformatf("vec%0d_st", r),  32'(state_o),  32'(tbl[r].exp_st));
    end

    // Round-robin spacing of simultaneous requests.
    do_reset();
    wake = 4'b1011;
    for (int d = 0; d < N; d++) rise[d] = -1;
    for (int k = 1; k <= 16; k++) begin
      tick(1'b1);
      for (int d = 0; d < N; d++)
        if (clk_en_o[d] && rise[d] < 0) rise[d] = k;
    end
    check("rr_rise_d0", 32'(rise[0]), 32'(1));
    check("rr_rise_d1", 32'(rise[1]), 32'(6));
    check("rr_rise_d3", 32'(rise[3]), 32'(11));
    check("rr_rise_d2", 32'(rise[2]), 32'hFFFF_FFFF);
    wake = '0;
    for (int k = 0; k < 40; k++) tick(1'b1);
    check("rr_all_off", 32'(clk_en_o), 32'h0);
    wake = 4'b0011;
    tick(1'b1);
    check("rr_ptr_wrap", 32'(clk_en_o), 32'h1);
    wake = '0;
    for (int k = 0; k < 30; k++) tick(1'b1);

    // Idle gating latency, then a one-cycle busy pulse restarting the count.
    do_reset();
    busy = 4'b0001;
    for (int k = 0; k < 6; k++) tick(1'b1);
    check("gate_ready", 32'(ready_o[0]), 32'h1);
    busy = '0;
    drop = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1);
      if (!clk_en_o[0] && drop < 0) drop = k;
    end
    check("gate_drop", 32'(drop), 32'(17));
    busy = 4'b0001;
    for (int k = 0; k < 6; k++) tick(1'b1);
    drop = -1;
    for (int k = 1; k <= 32; k++) begin
      busy[0] = (k == 11);
      tick(1'b1);
      if (k == 17) check("pulse_hold", 32'(clk_en_o[0]), 32'h1);
      if (!clk_en_o[0] && drop < 0) drop = k;
    end
    check("pulse_drop", 32'(drop), 32'(28));
    busy = '0;

    // force_on keeps a domain running indefinitely.
    do_reset();
    frc = 4'b0100;
    viol = 0;
    for (int k = 1; k <= 200; k++) begin
      tick(1'b1);
      if (clk_en_o[2] !== 1'b1) viol++;
    end
    check("force_viol", 32'(viol), 32'h0);
    check("force_state", 32'(state_o[5:4]), 32'h2);
    check("force_ready", 32'(ready_o), 32'h4);
    frc = '0;

    // Asynchronous reset in the middle of a wake.
    do_reset();
    wake = 4'b0001;
    tick(1'b1);
    tick(1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_clk_en", 32'(clk_en_o), 32'h0);
    check("arst_ready",  32'(ready_o),  32'h0);
    check("arst_state",  32'(state_o),  32'h0);
    model_reset();
    wake = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wake = 4'b1001;
    tick(1'b1);
    check("arst_ptr0", 32'(clk_en_o), 32'h1);
    for (int k = 2; k <= 5; k++) tick(1'b1);
    check("arst_ready_lat", 32'(ready_o), 32'h1);
    check("arst_state_on", 32'(state_o[1:0]), 32'h2);
    wake = '0;

    // Random traffic against the model, with one reset in the middle.
    for (int k = 0; k < 2500; k++) begin
      if (k == 1200) do_reset();
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(7) == 0) busy[d] = ~busy[d];
        wake[d] = ($urandom_range(15) == 0);
        if ($urandom_range(199) == 0) frc[d] = ~frc[d];
      end
      if ($urandom_range(49) == 0) test_en = ~test_en;
      tick(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
